// File: rtl/addsub_arb_unit.sv
// ---------------------------------------------------------------------------
// addsub_arb_unit
//
// Round-robin arbitrated signed add/subtract unit. NUM_CH requesters each
// offer an operand pair and an op select; one channel is granted per cycle
// and its result is registered into a single output stage.
//
// Parameters
//   WIDTH   operand/result width in bits (2..64)
//   NUM_CH  number of requesting channels (2..8)
//   CH_W    channel index width, max(1, clog2(NUM_CH))
//
// Ports
//   i_clk    clock, all state updates on the rising edge
//   i_rst    synchronous active-high reset
//   i_valid  [NUM_CH]        per-channel request valid
//   o_ready  [NUM_CH]        per-channel request accepted this cycle (one-hot or 0)
//   i_mode   [NUM_CH]        per-channel op: 0 = a+b, 1 = a-b
//   i_a      [NUM_CH*WIDTH]  channel k operand a at [k*WIDTH +: WIDTH]
//   i_b      [NUM_CH*WIDTH]  channel k operand b, same packing
//   o_valid                  result valid
//   i_ready                  downstream accepts the result
//   o_ch     [CH_W]          channel that produced o_res
//   o_res    [WIDTH]         signed result
//   o_ovf                    signed overflow flag for o_res
//
// Handshake: a transfer happens on any cycle where valid and ready are both
// 1 on the same link (i_valid[k]/o_ready[k] upstream, o_valid/i_ready
// downstream). Valid never depends on ready; o_ready depends on i_valid,
// i_rst, o_valid and i_ready, so a drain and a new accept can share a cycle.
//
// Configuration
//   ADDSUB_ARB_UNIT_SAT_EN  defined: overflowing results saturate to the
//                           signed max/min. Undefined (default): results
//                           wrap modulo 2^WIDTH. o_ovf is the same in both.
// ---------------------------------------------------------------------------
module addsub_arb_unit #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 2,
  localparam int CH_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_CH-1:0]       i_valid,
  output logic [NUM_CH-1:0]       o_ready,
  input  logic [NUM_CH-1:0]       i_mode,
  input  logic [NUM_CH*WIDTH-1:0] i_a,
  input  logic [NUM_CH*WIDTH-1:0] i_b,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [CH_W-1:0]         o_ch,
  output logic [WIDTH-1:0]        o_res,
  output logic                    o_ovf
);

  // Registered state
  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic [CH_W-1:0]  ch_q,     ch_d;
  logic             ovf_q,    ovf_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;

  // Arbitration
  logic [NUM_CH-1:0] grant_oh;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_found;
  logic              accept;
  logic              take;
  logic [CH_W:0]     cand;
  logic [CH_W:0]     next_ptr;

  // Datapath
  logic             sel_mode;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] raw;
  logic             ovf;
  logic [WIDTH-1:0] res_final;

  // The output stage can take a new result when empty or draining this cycle.
  assign accept = !i_rst && (!valid_q || i_ready);

  // First requester at or after rr_ptr, searching upward modulo NUM_CH.
  // cand is one bit wider than the index so the wrap compare cannot overflow.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      cand = {1'b0, rr_ptr_q} + (CH_W+1)'(off);
      if (cand >= (CH_W+1)'(NUM_CH)) begin
        cand = cand - (CH_W+1)'(NUM_CH);
      end
      if (!grant_found && i_valid[cand[CH_W-1:0]]) begin
        grant_found                = 1'b1;
        grant_idx                  = cand[CH_W-1:0];
        grant_oh[cand[CH_W-1:0]]   = 1'b1;
      end
    end
  end

  assign o_ready = grant_oh & {NUM_CH{accept}};
  assign take    = grant_found && accept;

  // Operand mux: only the granted channel's slice is ever used.
  always_comb begin
    sel_mode = 1'b0;
    sel_a    = '0;
    sel_b    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_idx == CH_W'(k)) begin
        sel_mode = i_mode[k];
        sel_a    = i_a[k*WIDTH +: WIDTH];
        sel_b    = i_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Subtract is a + ~b + 1, so a single overflow rule covers both ops:
  // equal signs on a and the effective b, with a result sign differing from a.
  always_comb begin
    b_eff = sel_mode ? ~sel_b : sel_b;
    raw   = sel_a + b_eff + {{(WIDTH-1){1'b0}}, sel_mode};
    ovf   = (sel_a[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != sel_a[WIDTH-1]);
`ifdef ADDSUB_ARB_UNIT_SAT_EN
    // Overflow direction follows the sign of a: negative a -> min, else max.
    if (ovf) begin
      res_final = sel_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_final = raw;
    end
`else
    res_final = raw;
`endif
  end

  // Next-state logic for the output stage and the round-robin pointer.
  always_comb begin
    valid_d  = valid_q;
    res_d    = res_q;
    ch_d     = ch_q;
    ovf_d    = ovf_q;
    rr_ptr_d = rr_ptr_q;
    next_ptr = {1'b0, grant_idx} + (CH_W+1)'(1);
    if (next_ptr >= (CH_W+1)'(NUM_CH)) begin
      next_ptr = '0;
    end
    if (take) begin
      valid_d  = 1'b1;
      res_d    = res_final;
      ch_d     = grant_idx;
      ovf_d    = ovf;
      rr_ptr_d = next_ptr[CH_W-1:0];
    end else if (valid_q && i_ready) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      res_q    <= '0;
      ch_q     <= '0;
      ovf_q    <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      res_q    <= res_d;
      ch_q     <= ch_d;
      ovf_q    <= ovf_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_res   = res_q;
  assign o_ch    = ch_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_addsub_arb_unit.sv
// ---------------------------------------------------------------------------
// tb_addsub_arb_unit
//
// Bench for addsub_arb_unit at WIDTH=8, NUM_CH=2. A negedge monitor keeps a
// reference model of the arbiter and output stage: it predicts o_ready and
// o_valid, pushes the expected {ch, res, ovf} when a request transfer is
// predicted and pops/compares it when a result transfer happens. Scenario
// tasks add directed checks. Honors ADDSUB_ARB_UNIT_SAT_EN like the design.
// ---------------------------------------------------------------------------
module tb_addsub_arb_unit;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 2;
  localparam int EW     = 1 + WIDTH + 1;
`ifdef ADDSUB_ARB_UNIT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                    i_clk;
  logic                    i_rst;
  logic [NUM_CH-1:0]       i_valid;
  logic [NUM_CH-1:0]       o_ready;
  logic [NUM_CH-1:0]       i_mode;
  logic [NUM_CH*WIDTH-1:0] i_a;
  logic [NUM_CH*WIDTH-1:0] i_b;
  logic                    o_valid;
  logic                    i_ready;
  logic [0:0]              o_ch;
  logic [WIDTH-1:0]        o_res;
  logic                    o_ovf;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  addsub_arb_unit #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_mode  (i_mode),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_ch    (o_ch),
    .o_res   (o_res),
    .o_ovf   (o_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic          m_valid;
  int            m_ptr;

  function automatic logic [EW-1:0] model_op(input int ch, input logic mode,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    int sa, sb, r;
    logic o;
    logic [WIDTH-1:0] res;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    r   = mode ? (sa - sb) : (sa + sb);
    o   = (r > 127) || (r < -128);
    res = r[WIDTH-1:0];
    if (o && SAT) res = (r > 127) ? 8'h7F : 8'h80;
    return {ch[0], res, o};
  endfunction

  always @(negedge i_clk) begin : monitor
    logic [NUM_CH-1:0] exp_rdy;
    logic [EW-1:0]     exp_item;
    int                idx;
    int                g;
    if (i_rst === 1'b1) begin
      n_checks++;
      if (o_ready !== '0) begin
        n_fail++;
        $display("FAIL mon_rst_ready: got %b want 00", o_ready);
      end
      m_valid = 1'b0;
      m_ptr   = 0;
      exp_q.delete();
    end else begin
      exp_rdy = '0;
      g       = -1;
      if (!m_valid || i_ready) begin
        for (int off = 0; off < NUM_CH; off++) begin
          idx = (m_ptr + off) % NUM_CH;
          if (g < 0 && i_valid[idx]) g = idx;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      n_checks++;
      if (o_valid !== m_valid) begin
        n_fail++;
        $display("FAIL mon_valid: got %b want %b", o_valid, m_valid);
      end
      n_checks++;
      if (o_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL mon_ready: got %b want %b", o_ready, exp_rdy);
      end
      if (m_valid && i_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty: result ch=%0d res=%h with no expectation", o_ch, o_res);
        end else begin
          exp_item = exp_q.pop_front();
          if ({o_ch, o_res, o_ovf} !== exp_item) begin
            n_fail++;
            $display("FAIL sb_result: got ch=%0d res=%h ovf=%b want ch=%0d res=%h ovf=%b",
                     o_ch, o_res, o_ovf, exp_item[EW-1], exp_item[WIDTH:1], exp_item[0]);
          end
        end
        m_valid = 1'b0;
      end
      if (g >= 0) begin
        exp_q.push_back(model_op(g, i_mode[g], i_a[g*WIDTH +: WIDTH], i_b[g*WIDTH +: WIDTH]));
        m_valid = 1'b1;
        m_ptr   = (g + 1) % NUM_CH;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic mode,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    i_mode[k]           = mode;
    i_a[k*WIDTH +: WIDTH] = a;
    i_b[k*WIDTH +: WIDTH] = b;
  endtask

  function automatic logic [WIDTH-1:0] pick_op();
    case ($urandom_range(0, 4))
      0:       return 8'h7F;
      1:       return 8'h80;
      2:       return 8'hFF;
      3:       return 8'h00;
      default: return WIDTH'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst   = 1'b1;
    i_valid = 2'b11;
    i_ready = 1'b1;
    i_mode  = '0;
    i_a     = '0;
    i_b     = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    n_checks++;
    if (o_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", o_ready); end
    n_checks++;
    if ({o_valid, o_res, o_ch, o_ovf} !== '0) begin
      n_fail++;
      $display("FAIL rst_state: got valid=%b res=%h ch=%0d ovf=%b want all 0", o_valid, o_res, o_ch, o_ovf);
    end
    cycle();
    i_rst   = 1'b0;
    i_valid = 2'b00;
  endtask

  task automatic test_round_robin();
    cycle();
    set_ch(0, 1'b0, 8'd11, 8'd1);
    set_ch(1, 1'b1, 8'd20, 8'd7);
    i_valid = 2'b11;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      @(negedge i_clk);
      n_checks++;
      if (o_ch !== 1'(i % 2)) begin
        n_fail++;
        $display("FAIL rr_ch[%0d]: got %0d want %0d", i, o_ch, i % 2);
      end
    end
    cycle();
    i_valid = 2'b00;
    cycle();
  endtask

  task automatic test_add();
    cycle();
    set_ch(0, 1'b0, 8'd5, 8'd3);
    i_valid = 2'b01;
    i_ready = 1'b1;
    cycle();
    i_valid = 2'b00;
    @(negedge i_clk);
    n_checks++;
    if ({o_valid, o_res, o_ch, o_ovf} !== {1'b1, 8'd8, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_5_3: got valid=%b res=%h ch=%0d ovf=%b want 1 08 0 0", o_valid, o_res, o_ch, o_ovf);
    end
    cycle();
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] want;
    cycle();
    // Channel 0 carries a decoy that would not overflow.
    set_ch(0, 1'b0, 8'h01, 8'h01);
    set_ch(1, 1'b1, 8'h80, 8'h01);
    i_valid = 2'b10;
    i_ready = 1'b1;
    cycle();
    set_ch(1, 1'b0, 8'h7F, 8'h01);
    @(negedge i_clk);
    want = SAT ? 8'h80 : 8'h7F;
    n_checks++;
    if ({o_ch, o_res, o_ovf} !== {1'b1, want, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_sub: got ch=%0d res=%h ovf=%b want 1 %h 1", o_ch, o_res, o_ovf, want);
    end
    cycle();
    i_valid = 2'b00;
    @(negedge i_clk);
    want = SAT ? 8'h7F : 8'h80;
    n_checks++;
    if ({o_ch, o_res, o_ovf} !== {1'b1, want, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_add: got ch=%0d res=%h ovf=%b want 1 %h 1", o_ch, o_res, o_ovf, want);
    end
    cycle();
  endtask

  task automatic test_backpressure();
    cycle();
    i_ready = 1'b0;
    set_ch(0, 1'b0, 8'd10, 8'd20);
    i_valid = 2'b01;
    cycle();
    set_ch(0, 1'b1, 8'hFD, 8'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_ready !== 2'b00 || o_valid !== 1'b1 || o_res !== 8'd30) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got ready=%b valid=%b res=%h want 00 1 1e", i, o_ready, o_valid, o_res);
      end
      if (i < 2) cycle();
    end
    cycle();
    i_ready = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (o_ready !== 2'b01 || o_res !== 8'd30) begin
      n_fail++;
      $display("FAIL bp_release: got ready=%b res=%h want 01 1e", o_ready, o_res);
    end
    cycle();
    i_valid = 2'b00;
    @(negedge i_clk);
    n_checks++;
    if ({o_valid, o_ch, o_res, o_ovf} !== {1'b1, 1'b0, 8'hF9, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_next: got valid=%b ch=%0d res=%h ovf=%b want 1 0 f9 0", o_valid, o_ch, o_res, o_ovf);
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    cycle();
    i_ready = 1'b0;
    set_ch(0, 1'b0, 8'd1, 8'd2);
    i_valid = 2'b01;
    cycle();
    i_valid = 2'b00;
    @(negedge i_clk);
    n_checks++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pending: got valid=%b want 1", o_valid); end
    cycle();
    i_rst = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (o_ready !== 2'b00) begin n_fail++; $display("FAIL rm_ready: got %b want 00", o_ready); end
    cycle();
    i_rst   = 1'b0;
    i_valid = 2'b11;
    i_ready = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rm_after: got valid=%b ready=%b want 0 01", o_valid, o_ready);
    end
    cycle();
    i_valid = 2'b00;
    @(negedge i_clk);
    n_checks++;
    if (o_valid !== 1'b1 || o_ch !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_first_grant: got valid=%b ch=%0d want 1 0", o_valid, o_ch);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      cycle();
      i_valid = NUM_CH'($urandom_range(0, 3));
      i_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NUM_CH; k++) begin
        set_ch(k, 1'($urandom_range(0, 1)), pick_op(), pick_op());
      end
    end
    cycle();
    i_valid = 2'b00;
    i_ready = 1'b1;
    cycle();
    cycle();
    @(negedge i_clk);
    n_checks++;
    if (exp_q.size() != 0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got queue=%0d valid=%b want 0 0", exp_q.size(), o_valid);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_round_robin();
    test_add();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
